j2_stack_state: RTL and testbench

- Architectural state stage of the j2 core, directly downstream of the combinational ALU.
- Holds the following state and feeds it back to the ALU as next-cycle operands:
  - program counter
  - data-stack top register (T)
  - data and return stack arrays
  - both stack pointers
  - sticky stack-fault flags
- Each enabled clock commits the ALU's next-state outputs.

---
 rtl/j2_stack_state.sv | 111 +++++++++++
 tb/tb_j2_stack_state.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/j2_stack_state.sv
// j2 architectural state: PC, T register, data/return stacks, pointers,
// occupancy counters and sticky stack-fault flags. Commits ALU next-state on ce.
module j2_stack_state #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 13
) (
  input  logic                clk,
  input  logic                resetq,
  input  logic                ce,
  input  logic [PC_WIDTH-1:0] program_counter_next_value,
  input  logic [WIDTH-1:0]    data_stack_next_value,
  input  logic [DEPTH-1:0]    data_stack_next_write_position,
  input  logic                data_stack_next_write,
  input  logic [DEPTH-1:0]    return_stack_next_write_position,
  input  logic                return_stack_next_write,
  input  logic [WIDTH-1:0]    return_stack_write_data,
  input  logic                clear_faults,
  output logic [PC_WIDTH-1:0] program_counter,
  output logic [DEPTH-1:0]    data_stack_read_position,
  output logic [WIDTH-1:0]    data_stack_current_top,
  output logic [WIDTH-1:0]    data_stack_current_next_top,
  output logic [DEPTH-1:0]    return_stack_read_position,
  output logic [WIDTH-1:0]    return_stack_current_top,
  output logic [DEPTH:0]      data_stack_depth,
  output logic                data_overflow,
  output logic                data_underflow,
  output logic                return_overflow,
  output logic                return_underflow
);
  localparam int ENTRIES = 2 ** DEPTH;
  localparam int NSTK    = 2;

  logic [WIDTH-1:0] data_stack   [ENTRIES];
  logic [WIDTH-1:0] return_stack [ENTRIES];

  logic [NSTK-1:0][DEPTH-1:0] cur_pos, nxt_pos;
  logic [NSTK-1:0][DEPTH:0]   occ;
  logic [NSTK-1:0]            ovf_flag, unf_flag;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      program_counter            <= '0;
      data_stack_read_position   <= '0;
      return_stack_read_position <= '0;
      data_stack_current_top     <= '0;
    end else if (ce) begin
      program_counter            <= program_counter_next_value;
      data_stack_read_position   <= data_stack_next_write_position;
      return_stack_read_position <= return_stack_next_write_position;
      data_stack_current_top     <= data_stack_next_value;
    end
  end

  // Arrays carry no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (ce && resetq) begin
      if (data_stack_next_write)
        data_stack[data_stack_next_write_position] <= data_stack_current_top;
      if (return_stack_next_write)
        return_stack[return_stack_next_write_position] <= return_stack_write_data;
    end
  end

  assign data_stack_current_next_top = data_stack[data_stack_read_position];
  assign return_stack_current_top    = return_stack[return_stack_read_position];

  assign cur_pos[0] = data_stack_read_position;
  assign nxt_pos[0] = data_stack_next_write_position;
  assign cur_pos[1] = return_stack_read_position;
  assign nxt_pos[1] = return_stack_next_write_position;

  // Per-stack occupancy: pointer movement read as a signed step, count
  // saturates at ENTRIES and clamps at 0, raising the sticky flags.
  for (genvar s = 0; s < NSTK; s++) begin : g_occ
    logic signed [DEPTH-1:0] delta;
    logic [DEPTH+1:0]        sum;
    logic [DEPTH:0]          cnt;
    logic                    ovf, unf, ovf_q, unf_q;

    always_comb begin
      delta = nxt_pos[s] - cur_pos[s];
      sum   = {1'b0, cnt} + {{2{delta[DEPTH-1]}}, delta};
      unf   = sum[DEPTH+1];
      ovf   = !sum[DEPTH+1] && (sum[DEPTH:0] > {1'b1, {DEPTH{1'b0}}});
    end

    always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
        cnt   <= '0;
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else if (ce) begin
        cnt   <= ovf ? {1'b1, {DEPTH{1'b0}}} : (unf ? '0 : sum[DEPTH:0]);
        ovf_q <= ovf | (ovf_q & ~clear_faults);
        unf_q <= unf | (unf_q & ~clear_faults);
      end
    end

    assign occ[s]      = cnt;
    assign ovf_flag[s] = ovf_q;
    assign unf_flag[s] = unf_q;
  end

  assign data_stack_depth = occ[0];
  assign data_overflow    = ovf_flag[0];
  assign data_underflow   = unf_flag[0];
  assign return_overflow  = ovf_flag[1];
  assign return_underflow = unf_flag[1];

endmodule

// File: tb/tb_j2_stack_state.sv
// Directed bench for j2_stack_state: commit, push/pop, call/return, stall,
// fault flags with saturation/clear, and asynchronous reset.
module tb_j2_stack_state;
  logic        clk = 1'b0;
  logic        resetq, ce;
  logic [12:0] pc_nx;
  logic [15:0] t_nx;
  logic [3:0]  dp_nx;
  logic        dw;
  logic [3:0]  rp_nx;
  logic        rw;
  logic [15:0] rdata;
  logic        clr;
  logic [12:0] pc;
  logic [3:0]  dp, rp;
  logic [15:0] t, n, r;
  logic [4:0]  depth;
  logic        dov, dun, rov, run;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  j2_stack_state dut (
    .clk(clk), .resetq(resetq), .ce(ce),
    .program_counter_next_value(pc_nx),
    .data_stack_next_value(t_nx),
    .data_stack_next_write_position(dp_nx),
    .data_stack_next_write(dw),
    .return_stack_next_write_position(rp_nx),
    .return_stack_next_write(rw),
    .return_stack_write_data(rdata),
    .clear_faults(clr),
    .program_counter(pc),
    .data_stack_read_position(dp),
    .data_stack_current_top(t),
    .data_stack_current_next_top(n),
    .return_stack_read_position(rp),
    .return_stack_current_top(r),
    .data_stack_depth(depth),
    .data_overflow(dov), .data_underflow(dun),
    .return_overflow(rov), .return_underflow(run)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic commit(input logic [12:0] p, input logic [15:0] tv, input logic [3:0] d,
                        input logic w, input logic [3:0] rr, input logic rwv,
                        input logic [15:0] rd, input logic c);
    @(negedge clk);
    ce = 1'b1; pc_nx = p; t_nx = tv; dp_nx = d; dw = w;
    rp_nx = rr; rw = rwv; rdata = rd; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pc"}, 32'(pc), 0);
    chk({tag, ".t"}, 32'(t), 0);
    chk({tag, ".dp"}, 32'(dp), 0);
    chk({tag, ".rp"}, 32'(rp), 0);
    chk({tag, ".depth"}, 32'(depth), 0);
    chk({tag, ".flags"}, 32'({dov, dun, rov, run}), 0);
  endtask

  initial begin
    resetq = 1'b0; ce = 1'b1; pc_nx = '0; t_nx = '0; dp_nx = '0; dw = 1'b0;
    rp_nx = '0; rw = 1'b0; rdata = '0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) resetq = 1'b1;

    // basic commit
    commit(13'h0005, 16'h1234, 4'h0, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    chk("commit.pc", 32'(pc), 32'h5);
    chk("commit.t", 32'(t), 32'h1234);
    chk("commit.ptrs", 32'({dp, rp}), 0);
    chk("commit.depth", 32'(depth), 0);
    chk("commit.flags", 32'({dov, dun, rov, run}), 0);

    // three literal pushes
    commit(13'h6, 16'hAAAA, 4'h1, 1'b1, 4'h0, 1'b0, 16'h0, 1'b0);
    commit(13'h7, 16'hBBBB, 4'h2, 1'b1, 4'h0, 1'b0, 16'h0, 1'b0);
    commit(13'h8, 16'hCCCC, 4'h3, 1'b1, 4'h0, 1'b0, 16'h0, 1'b0);
    chk("push.t", 32'(t), 32'hCCCC);
    chk("push.n", 32'(n), 32'hBBBB);
    chk("push.depth", 32'(depth), 3);
    chk("push.dp", 32'(dp), 3);
    // pop exposes data_stack[2]
    commit(13'h9, 16'hBBBB, 4'h2, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    chk("pop.n", 32'(n), 32'hAAAA);
    chk("pop.depth", 32'(depth), 2);

    // call / return
    commit(13'h00A, 16'hBBBB, 4'h2, 1'b0, 4'h1, 1'b1, 16'h0042, 1'b0);
    chk("call.r", 32'(r), 32'h0042);
    chk("call.rp", 32'(rp), 1);
    commit(13'h042, 16'hBBBB, 4'h2, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    chk("ret.rp", 32'(rp), 0);
    chk("ret.pc", 32'(pc), 32'h42);

    // stall with changing inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ce = 1'b0; pc_nx = 13'($urandom); t_nx = 16'($urandom); dp_nx = 4'hF - 4'(i);
      dw = 1'b1; rp_nx = 4'(i + 8); rw = 1'b1; rdata = 16'($urandom); clr = 1'b1;
      @(posedge clk); #1;
      chk("stall.pc", 32'(pc), 32'h42);
      chk("stall.t", 32'(t), 32'hBBBB);
      chk("stall.n", 32'(n), 32'hAAAA);
      chk("stall.ptrs", 32'({dp, rp}), 32'h20);
      chk("stall.depth", 32'(depth), 2);
      chk("stall.flags", 32'({dov, dun, rov, run}), 0);
    end
    commit(13'h100, 16'h5555, 4'h3, 1'b1, 4'h0, 1'b0, 16'h0, 1'b0);
    chk("resume.t", 32'(t), 32'h5555);
    chk("resume.n", 32'(n), 32'hBBBB);
    chk("resume.depth", 32'(depth), 3);

    // data underflow from reset
    @(negedge clk) resetq = 1'b0;
    #2 resetq = 1'b1;
    commit(13'h1, 16'h0, 4'hF, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    chk("dunf.flag", 32'(dun), 1);
    chk("dunf.depth", 32'(depth), 0);
    chk("dunf.dp", 32'(dp), 32'hF);
    chk("dunf.others", 32'({dov, rov, run}), 0);

    // 17 return pushes: saturate and wrap
    for (int i = 1; i <= 17; i++)
      commit(13'(i), 16'h0, 4'hF, 1'b0, 4'(i), 1'b1, 16'(i), 1'b0);
    chk("rovf.flag", 32'(rov), 1);
    chk("rovf.rp", 32'(rp), 1);
    chk("rovf.r", 32'(r), 32'h11);
    chk("rovf.dunf_sticky", 32'(dun), 1);

    commit(13'h0, 16'h0, 4'hF, 1'b0, 4'h1, 1'b0, 16'h0, 1'b1);
    chk("clear.flags", 32'({dov, dun, rov, run}), 0);

    // 16 pops from a saturated count are clean, the 17th underflows
    for (int k = 1; k <= 16; k++)
      commit(13'h0, 16'h0, 4'hF, 1'b0, 4'(1 - k), 1'b0, 16'h0, 1'b0);
    chk("rpop16.unf", 32'(run), 0);
    chk("rpop16.rp", 32'(rp), 1);
    commit(13'h0, 16'h0, 4'hF, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    chk("rpop17.unf", 32'(run), 1);

    // clear ignored while stalled
    @(negedge clk); ce = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    chk("stallclr.unf", 32'(run), 1);
    // clear with a new data fault in the same edge: new fault survives
    commit(13'h0, 16'h0, 4'hE, 1'b0, 4'h0, 1'b0, 16'h0, 1'b1);
    chk("clrwin.dunf", 32'(dun), 1);
    chk("clrwin.runf", 32'(run), 0);

    // async reset between edges
    commit(13'h1ABC, 16'hDEAD, 4'h5, 1'b0, 4'h7, 1'b0, 16'h0, 1'b0);
    chk("pre_rst.pc", 32'(pc), 32'h1ABC);
    @(posedge clk); #3 resetq = 1'b0;
    #1 chk_zero("async_rst");
    #2 resetq = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
